// File: rtl/mat_pkg.sv
// ---------------------------------------------------------------------------
// mat_pkg
// Shared definitions for the mat_mult operand feeder.
//   A_W / B_W  : element widths of the X (unsigned) and Y (Q0.7) matrices
//   N          : matrix dimension (4x4)
//   a_elem_t / b_elem_t : element types
//   beat_t     : beat index {row, col}; row selects the X row, col the Y column
//   tag_t      : one tag-pipeline entry {valid, beat}
//   state_t    : feeder FSM states
// ---------------------------------------------------------------------------
package mat_pkg;

  localparam int A_W = 9;
  localparam int B_W = 8;
  localparam int N   = 4;

  typedef logic [A_W-1:0] a_elem_t;
  typedef logic [B_W-1:0] b_elem_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } beat_t;

  typedef struct packed {
    logic  valid;
    beat_t beat;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The final beat of a 4x4 sweep is row 3, column 3.
  function automatic logic is_last_beat(input beat_t b);
    return (b.row == 2'd3) && (b.col == 2'd3);
  endfunction

endpackage

// File: rtl/feeder_tag_pipe.sv
// ---------------------------------------------------------------------------
// feeder_tag_pipe
// DEPTH-stage shift register carrying {valid, row, col} alongside the
// mat_mult datapath so the tag leaves exactly when the matching AB element
// does. It shifts every cycle, so stall bubbles travel through as valid = 0.
// Ports:
//   clk_80  : clock, rising edge
//   rst_80  : asynchronous active-low reset, clears every stage
//   i_tag   : tag entering stage 0
//   o_tag   : tag leaving the last stage
// ---------------------------------------------------------------------------
module feeder_tag_pipe
  import mat_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_80,
  input  logic rst_80,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mat_mult_feeder.sv
// ---------------------------------------------------------------------------
// mat_mult_feeder
// Operand sequencer in front of mat_mult. Stores a 4x4 X matrix (unsigned)
// and a 4x4 Y matrix (Q0.7, stored verbatim), then on start streams 16 beats
// in row-major order: beat n = {i, j} presents row i of X on A0..A3 and
// column j of Y on B0..B3. A MULT_LAT-deep tag pipeline tells downstream
// capture logic which AB element mat_mult is producing.
// Ports:
//   clk_80, rst_80          : clock / asynchronous active-low reset
//   wr_en_80, wr_sel_80     : write strobe (IDLE only), 0 = X, 1 = Y
//   wr_addr_80, wr_data_80  : element index row*4+col, write data
//   start_80                : start pulse (IDLE only)
//   hold_80                 : stall, freezes the beat sequence in RUN
//   A00_80..A03_80          : X[i][0..3]
//   B00_80..B03_80          : Y[0..3][j]
//   op_valid_80             : operands valid this cycle
//   res_valid_80, res_row_80, res_col_80 : tag delayed by MULT_LAT
//   busy_80                 : RUN or DRAIN
//   done_80                 : pulse with the final result tag
// ---------------------------------------------------------------------------
module mat_mult_feeder #(
  parameter int A_W      = mat_pkg::A_W,
  parameter int B_W      = mat_pkg::B_W,
  parameter int MULT_LAT = 2
) (
  input  logic           clk_80,
  input  logic           rst_80,
  input  logic           wr_en_80,
  input  logic           wr_sel_80,
  input  logic [3:0]     wr_addr_80,
  input  logic [A_W-1:0] wr_data_80,
  input  logic           start_80,
  input  logic           hold_80,
  output logic [A_W-1:0] A00_80,
  output logic [A_W-1:0] A01_80,
  output logic [A_W-1:0] A02_80,
  output logic [A_W-1:0] A03_80,
  output logic [B_W-1:0] B00_80,
  output logic [B_W-1:0] B01_80,
  output logic [B_W-1:0] B02_80,
  output logic [B_W-1:0] B03_80,
  output logic           op_valid_80,
  output logic           res_valid_80,
  output logic [1:0]     res_row_80,
  output logic [1:0]     res_col_80,
  output logic           busy_80,
  output logic           done_80
);

  import mat_pkg::*;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t         r_state;
  state_t         w_state_next;

  logic [A_W-1:0] r_x [16];
  logic [B_W-1:0] r_y [16];

  logic [A_W-1:0] r_a [4];
  logic [B_W-1:0] r_b [4];

  logic [3:0]     r_cnt;        // next beat to present: [3:2] = i, [1:0] = j
  logic           r_op_valid;
  beat_t          r_op_beat;    // beat currently on the operand outputs

  logic [1:0]     w_row;
  logic [1:0]     w_col;
  logic           w_present;
  logic           w_done;
  tag_t           w_tag_in;
  tag_t           w_tag_out;

  assign w_row     = r_cnt[3:2];
  assign w_col     = r_cnt[1:0];
  assign w_present = (r_state == RUN) && !hold_80;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_80) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_present && (r_cnt == 4'd15)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage and operand registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      for (int k = 0; k < 16; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_cnt      <= '0;
      r_op_valid <= 1'b0;
      r_op_beat  <= '0;
    end else begin
      // op_valid is high only on cycles that present a fresh beat.
      r_op_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // The write lands on the same edge that samples start, so a
          // same-cycle write is already in storage when beat 0 is read.
          if (wr_en_80) begin
            if (wr_sel_80) begin
              r_y[wr_addr_80] <= wr_data_80[B_W-1:0];
            end else begin
              r_x[wr_addr_80] <= wr_data_80;
            end
          end
          if (start_80) begin
            r_cnt <= '0;
          end
        end
        RUN: begin
          if (w_present) begin
            for (int k = 0; k < 4; k++) begin
              r_a[k] <= r_x[{w_row, 2'(k)}];
              r_b[k] <= r_y[{2'(k), w_col}];
            end
            r_op_valid     <= 1'b1;
            r_op_beat.row  <= w_row;
            r_op_beat.col  <= w_col;
            r_cnt          <= r_cnt + 4'd1;
          end
        end
        default: begin
          // DRAIN: operands keep the last beat, nothing new is presented.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline, aligned to mat_mult latency
  // -------------------------------------------------------------------------
  assign w_tag_in = {r_op_valid, r_op_beat};

  feeder_tag_pipe #(
    .DEPTH (MULT_LAT)
  ) u_tag_pipe (
    .clk_80 (clk_80),
    .rst_80 (rst_80),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  // Beat 15 is always presented before DRAIN is entered, so its tag can only
  // exit while in DRAIN.
  assign w_done = (r_state == DRAIN) && w_tag_out.valid && is_last_beat(w_tag_out.beat);

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign A00_80       = r_a[0];
  assign A01_80       = r_a[1];
  assign A02_80       = r_a[2];
  assign A03_80       = r_a[3];
  assign B00_80       = r_b[0];
  assign B01_80       = r_b[1];
  assign B02_80       = r_b[2];
  assign B03_80       = r_b[3];
  assign op_valid_80  = r_op_valid;
  assign res_valid_80 = w_tag_out.valid;
  assign res_row_80   = w_tag_out.beat.row;
  assign res_col_80   = w_tag_out.beat.col;
  assign busy_80      = (r_state != IDLE);
  assign done_80      = w_done;

endmodule

// File: tb/tb_mat_mult_feeder.sv
// ---------------------------------------------------------------------------
// tb_mat_mult_feeder
// Directed bench for mat_mult_feeder with MULT_LAT = 2. Cycle k of a capture
// is the state visible after the k-th rising edge following the edge that
// sampled start (k = 0 is the first cycle after start).
// ---------------------------------------------------------------------------
module tb_mat_mult_feeder;

  logic       clk_80 = 1'b0;
  logic       rst_80;
  logic       wr_en_80, wr_sel_80, start_80, hold_80;
  logic [3:0] wr_addr_80;
  logic [8:0] wr_data_80;
  logic [8:0] A00_80, A01_80, A02_80, A03_80;
  logic [7:0] B00_80, B01_80, B02_80, B03_80;
  logic       op_valid_80, res_valid_80, busy_80, done_80;
  logic [1:0] res_row_80, res_col_80;

  always #5 clk_80 = ~clk_80;

  mat_mult_feeder #(
    .A_W(9), .B_W(8), .MULT_LAT(2)
  ) dut (
    .clk_80(clk_80), .rst_80(rst_80),
    .wr_en_80(wr_en_80), .wr_sel_80(wr_sel_80), .wr_addr_80(wr_addr_80),
    .wr_data_80(wr_data_80), .start_80(start_80), .hold_80(hold_80),
    .A00_80(A00_80), .A01_80(A01_80), .A02_80(A02_80), .A03_80(A03_80),
    .B00_80(B00_80), .B01_80(B01_80), .B02_80(B02_80), .B03_80(B03_80),
    .op_valid_80(op_valid_80), .res_valid_80(res_valid_80),
    .res_row_80(res_row_80), .res_col_80(res_col_80),
    .busy_80(busy_80), .done_80(done_80)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Y rows as loaded: Y[r][c]
  int yv [4][4] = '{'{13, 26, 38, 192}, '{77, 166, 154, 115},
                    '{102, 90, 77, 64}, '{205, 38, 230, 13}};

  int cap_a [64][4];
  int cap_b [64][4];
  int cap_ov[64], cap_rv[64], cap_rr[64], cap_rc[64], cap_dn[64], cap_bz[64];
  int sh[64];   // hold schedule: hold_80 value sampled by edge k
  int sp[64];   // poke schedule: write X[0]=511 + start sampled by edge k

  typedef struct {
    int beat;
    int a[4];
    int b[4];
  } vec_t;
  vec_t tbl[4];

  function automatic int xv(input int r, input int c);
    return 10 * (4 * r + c + 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic record(input int k);
    cap_a[k][0] = A00_80; cap_a[k][1] = A01_80; cap_a[k][2] = A02_80; cap_a[k][3] = A03_80;
    cap_b[k][0] = B00_80; cap_b[k][1] = B01_80; cap_b[k][2] = B02_80; cap_b[k][3] = B03_80;
    cap_ov[k] = op_valid_80; cap_rv[k] = res_valid_80;
    cap_rr[k] = res_row_80;  cap_rc[k] = res_col_80;
    cap_dn[k] = done_80;     cap_bz[k] = busy_80;
  endtask

  task automatic clear_sched();
    for (int k = 0; k < 64; k++) begin
      sh[k] = 0;
      sp[k] = 0;
    end
  endtask

  task automatic wr(input bit s, input int a, input int d);
    @(negedge clk_80);
    wr_en_80 = 1'b1; wr_sel_80 = s; wr_addr_80 = 4'(a); wr_data_80 = 9'(d);
    @(negedge clk_80);
    wr_en_80 = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, 4 * r + c, xv(r, c));
        wr(1'b1, 4 * r + c, yv[r][c]);
      end
    end
  endtask

  // Pulse start (optionally with a same-cycle write), then capture n cycles
  // while applying the hold / poke schedules.
  task automatic run(input int n, input bit we, input bit ws, input int wa, input int wd);
    @(negedge clk_80);
    start_80 = 1'b1; wr_en_80 = we; wr_sel_80 = ws;
    wr_addr_80 = 4'(wa); wr_data_80 = 9'(wd);
    @(negedge clk_80);
    start_80 = 1'b0; wr_en_80 = 1'b0;
    record(0);
    for (int k = 1; k < n; k++) begin
      hold_80 = (sh[k] != 0);
      if (sp[k] != 0) begin
        wr_en_80 = 1'b1; wr_sel_80 = 1'b0; wr_addr_80 = 4'd0; wr_data_80 = 9'd511;
        start_80 = 1'b1;
      end
      @(negedge clk_80);
      start_80 = 1'b0; wr_en_80 = 1'b0; hold_80 = 1'b0;
      record(k);
    end
  endtask

  // Compare captured cycle k with the operands of beat n of the loaded matrices.
  task automatic check_beat(input string nm, input int k, input int n);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s_k%0d_A%0d", nm, k, l), cap_a[k][l], xv(n / 4, l));
      chk($sformatf("%s_k%0d_B%0d", nm, k, l), cap_b[k][l], yv[l][n % 4]);
    end
  endtask

  initial begin
    rst_80 = 1'b0; wr_en_80 = 1'b0; wr_sel_80 = 1'b0; wr_addr_80 = '0;
    wr_data_80 = '0; start_80 = 1'b0; hold_80 = 1'b0;
    clear_sched();

    tbl[0] = '{beat: 0,  a: '{10, 20, 30, 40},     b: '{13, 77, 102, 205}};
    tbl[1] = '{beat: 1,  a: '{10, 20, 30, 40},     b: '{26, 166, 90, 38}};
    tbl[2] = '{beat: 4,  a: '{50, 60, 70, 80},     b: '{13, 77, 102, 205}};
    tbl[3] = '{beat: 15, a: '{130, 140, 150, 160}, b: '{192, 115, 64, 13}};

    repeat (2) @(negedge clk_80);
    rst_80 = 1'b1;
    @(negedge clk_80);
    chk("rst_A00", A00_80, 0);
    chk("rst_B03", B03_80, 0);
    chk("rst_op_valid", op_valid_80, 0);
    chk("rst_res_valid", res_valid_80, 0);
    chk("rst_busy", busy_80, 0);
    chk("rst_done", done_80, 0);

    // ---- Test 1/2: plain run, table vectors and tag timing ----
    load_all();
    run(24, 1'b0, 1'b0, 0, 0);
    for (int v = 0; v < 4; v++) begin
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("t1_beat%0d_A%0d", tbl[v].beat, l), cap_a[tbl[v].beat + 1][l], tbl[v].a[l]);
        chk($sformatf("t1_beat%0d_B%0d", tbl[v].beat, l), cap_b[tbl[v].beat + 1][l], tbl[v].b[l]);
      end
    end
    for (int n = 0; n < 16; n++) check_beat("t1", n + 1, n);
    chk("t1_busy_k0", cap_bz[0], 1);
    chk("t1_ov_k0", cap_ov[0], 0);
    for (int k = 1; k <= 16; k++) chk($sformatf("t1_ov_k%0d", k), cap_ov[k], 1);
    chk("t1_ov_k17", cap_ov[17], 0);
    chk("t1_drain_A00", cap_a[17][0], 130);
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("t1_rv_k%0d", k), cap_rv[k], (k >= 3 && k <= 18) ? 1 : 0);
      chk($sformatf("t1_done_k%0d", k), cap_dn[k], (k == 18) ? 1 : 0);
    end
    for (int k = 3; k <= 18; k++) begin
      chk($sformatf("t1_row_k%0d", k), cap_rr[k], (k - 3) / 4);
      chk($sformatf("t1_col_k%0d", k), cap_rc[k], (k - 3) % 4);
    end
    chk("t1_busy_k18", cap_bz[18], 1);
    chk("t1_busy_k19", cap_bz[19], 0);

    // ---- Test 3: three-cycle hold after beat 5 ----
    clear_sched();
    sh[7] = 1; sh[8] = 1; sh[9] = 1;
    run(26, 1'b0, 1'b0, 0, 0);
    clear_sched();
    for (int k = 6; k <= 9; k++) check_beat("t3_frozen", k, 5);
    for (int k = 7; k <= 9; k++) chk($sformatf("t3_ov_k%0d", k), cap_ov[k], 0);
    chk("t3_ov_k10", cap_ov[10], 1);
    check_beat("t3", 10, 6);
    check_beat("t3", 19, 15);
    chk("t3_rv_k8", cap_rv[8], 1);
    chk("t3_row_k8", cap_rr[8], 1);
    chk("t3_col_k8", cap_rc[8], 1);
    for (int k = 9; k <= 11; k++) chk($sformatf("t3_rv_k%0d", k), cap_rv[k], 0);
    chk("t3_rv_k12", cap_rv[12], 1);
    chk("t3_col_k12", cap_rc[12], 2);
    for (int k = 0; k < 26; k++) chk($sformatf("t3_done_k%0d", k), cap_dn[k], (k == 21) ? 1 : 0);
    chk("t3_busy_k22", cap_bz[22], 0);

    // ---- Test 4: write + start during RUN are ignored ----
    sp[5] = 1;
    run(28, 1'b0, 1'b0, 0, 0);
    clear_sched();
    for (int n = 0; n < 16; n++) check_beat("t4", n + 1, n);
    for (int k = 0; k < 28; k++) chk($sformatf("t4_done_k%0d", k), cap_dn[k], (k == 18) ? 1 : 0);
    for (int k = 19; k < 28; k++) chk($sformatf("t4_busy_k%0d", k), cap_bz[k], 0);
    run(4, 1'b0, 1'b0, 0, 0);
    chk("t4_rerun_A00", cap_a[1][0], 10);
    repeat (20) @(negedge clk_80);

    // ---- Test 5: asynchronous reset at beat 7 ----
    @(negedge clk_80); start_80 = 1'b1;
    @(negedge clk_80); start_80 = 1'b0;
    repeat (8) @(negedge clk_80);
    chk("t5_pre_A00", A00_80, 50);
    chk("t5_pre_B00", B00_80, 192);
    #2 rst_80 = 1'b0;
    #1;
    chk("t5_rst_A00", A00_80, 0);
    chk("t5_rst_B00", B00_80, 0);
    chk("t5_rst_op_valid", op_valid_80, 0);
    chk("t5_rst_res_valid", res_valid_80, 0);
    chk("t5_rst_busy", busy_80, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_80);
      chk($sformatf("t5_rst_done_c%0d", c), done_80, 0);
    end
    rst_80 = 1'b1;
    run(6, 1'b0, 1'b0, 0, 0);
    chk("t5_zero_ov", cap_ov[1], 1);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("t5_zero_A%0d", l), cap_a[1][l], 0);
      chk($sformatf("t5_zero_B%0d", l), cap_b[1][l], 0);
    end
    repeat (20) @(negedge clk_80);
    chk("t5_idle_busy", busy_80, 0);

    // ---- Test 6: same-cycle write of Y[3] = 99 with start ----
    load_all();
    run(8, 1'b1, 1'b1, 3, 99);
    chk("t6_beat0_B00", cap_b[1][0], 13);
    chk("t6_beat3_B00", cap_b[4][0], 99);
    repeat (20) @(negedge clk_80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mat_mult_feeder.md
Name: mat_mult_feeder

Overview:
- Operand sequencer directly upstream of mat_mult.
- Holds a 4x4 X matrix (9-bit unsigned) and a 4x4 Y matrix (8-bit two's-complement, Q0.7, e.g. 13 = 0.1, 205 = -0.4), both loaded through a simple write port.
- On start, streams 16 beats in row-major order: row i of X on A0..A3 and column j of Y on B0..B3.
- Emits latency-matched row/column tags so the downstream capture logic knows which AB element mat_mult is producing.

Parameters:
- A_W, 9, width of X elements / A operand ports
- B_W, 8, width of Y elements / B operand ports
- MULT_LAT, 2, mat_mult input-to-AB00 latency in cycles; sets the tag pipeline depth (legal 1..8)

Ports:
- clk_80  in  1  single clock, all state on rising edge
- rst_80  in  1  asynchronous, active-low reset
- wr_en_80  in  1  write strobe, honoured only in IDLE
- wr_sel_80  in  1  0 = X matrix, 1 = Y matrix
- wr_addr_80  in  4  element index, row*4+col
- wr_data_80  in  A_W  write data; Y writes use bits [B_W-1:0]
- start_80  in  1  one-cycle pulse, honoured only in IDLE
- hold_80  in  1  stall; freezes the beat sequence
- A00_80..A03_80  out  A_W each  X[i][0..3]
- B00_80..B03_80  out  B_W each  Y[0..3][j]
- op_valid_80  out  1  operands valid this cycle
- res_valid_80  out  1  op_valid_80 delayed by MULT_LAT
- res_row_80, res_col_80  out  2 each  i, j delayed by MULT_LAT
- busy_80  out  1  high in RUN or DRAIN
- done_80  out  1  one-cycle pulse coincident with the final res_valid_80

Behaviour:
- Reset (rst_80 low, async): FSM to IDLE; all X/Y storage, operand outputs, tag pipeline, counters and every output go to 0. A reset mid-operation aborts immediately with no done_80. The first start after reset streams all-zero operands unless the matrices are reloaded.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - A write with wr_en_80 commits at the clock edge.
  - start_80 moves to RUN and clears the beat counter (4 bits: i = [3:2], j = [1:0]).
  - If wr_en_80 and start_80 are high in the same cycle, the write commits and is visible in the streamed data.
- RUN:
  - Operand outputs are registered. First beat appears the cycle after start is sampled (latency 1).
  - Each non-held cycle presents beat n with op_valid_80 = 1, then increments n.
  - With hold_80 = 1: operands stay stable, op_valid_80 = 0, counter frozen, a 0 is inserted in the tag pipeline.
  - After beat 15 is presented, go to DRAIN.
- DRAIN:
  - Operands hold the last beat; op_valid_80 = 0.
  - The tag pipeline keeps shifting; hold_80 does not affect DRAIN.
  - When the beat-15 tag exits (res_valid_80 = 1, row 3, col 3), assert done_80 that same cycle and return to IDLE next edge.
- In RUN and DRAIN, wr_en_80 and start_80 are ignored (no storage change, no restart).
- Tag pipeline: MULT_LAT-stage shift of {op_valid, i, j}. It always shifts, so stall bubbles propagate as res_valid_80 = 0.
- Unstalled run length: 16 beats + MULT_LAT. busy_80 spans start+1 through the done cycle inclusive.
- No arithmetic in this block. Y data is stored verbatim; sign interpretation belongs to mat_mult.

Decomposition:
- Shared package mat_pkg holds:
  - A_W and B_W constants
  - N = 4 matrix dimension
  - typedefs a_elem_t and b_elem_t
  - typedef for beat index {row, col}
  - FSM state enum {IDLE, RUN, DRAIN}
- One sub-module: feeder_tag_pipe, a parameterised MULT_LAT-deep shift register for {valid, row, col}, with async active-low reset to 0.
- Storage and FSM stay in the top.

Test Plan:
1. Load X = 10,20,...,160 row-major and Y rows: {13,26,38,192}, {77,166,154,115}, {102,90,77,64}, {205,38,230,13}. Pulse start and expect:
   - beat 0: A = 10,20,30,40; B = 13,77,102,205
   - beat 1: B = 26,166,90,38
   - beat 4: A = 50,60,70,80; B = 13,77,102,205
   - beat 15: A = 130,140,150,160; B = 192,115,64,13
   - op_valid_80 high for 16 consecutive cycles.
2. Same load with MULT_LAT = 2 → res_valid_80 first high 3 cycles after start is sampled, with res_row/res_col = 0/0. Last tag is 3/3 with done_80 = 1, at 18 cycles after start; busy_80 low the next cycle.
3. Assert hold_80 for 3 cycles at beat 5 → A/B frozen at beat-5 values, op_valid_80 = 0 for 3 cycles, three res_valid_80 gaps appear MULT_LAT later, done_80 arrives 3 cycles late.
4. During RUN, write X[0] = 511 and pulse start again → stream unaffected, exactly one done_80. A following run shows A00_80 = 10 at beat 0.
5. Drop rst_80 low at beat 7 → all outputs 0 asynchronously, FSM in IDLE, no done_80. After release, start streams zeros.
6. In IDLE, same-cycle wr_en_80 (Y[3] = 99) and start_80 → beat 0 shows B00_80 = 13 and beat 3 shows B00_80 = 99.
